// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared constants, glyph table and hex decode helper
// for the multi-digit seven-segment controller.
package hex_disp_pkg;

  localparam int CTRL_OFS = 0;
  localparam int MASK_OFS = 1;
  localparam int STAT_OFS = 2;

  localparam int CTRL_DECODE = 0;
  localparam int CTRL_BLINK  = 1;
  localparam int CTRL_BLANK  = 2;

  localparam int SCAN_DIV = 1024;

  // bit0=a ... bit6=g, 1 = lit
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] nib
  );
    return HEX_GLYPH[nib];
  endfunction

endpackage

// File: rtl/hex_disp_ctrl_if.sv
// hex_disp_ctrl_if: Avalon-MM slave bus bundle for the
// seven-segment controller.
interface hex_disp_ctrl_if #(
  parameter int ADDR_W = 5
) ();

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/hex_disp_prescaler.sv
// hex_disp_prescaler: counts 0..DIV-1 while enabled and toggles
// phase on each wrap; clear holds count at 0 and phase at 1.
module hex_disp_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic phase
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/hex_disp_ctrl.sv
// hex_disp_ctrl: Avalon-MM multi-digit seven-segment controller.
// Define HEX_DISP_SCAN_EN to add the multiplexed scan outputs.
module hex_disp_ctrl
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int ADDR_W     = 5,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hex_disp_ctrl_if.slave          bus,
`ifdef HEX_DISP_SCAN_EN
  output logic [6:0]              scan_seg,
  output logic [NUM_DIGITS-1:0]   scan_sel,
`endif
  output logic [NUM_DIGITS*7-1:0] seg_out
);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_DIGITS + CTRL_OFS);
  localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(NUM_DIGITS + MASK_OFS);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_DIGITS + STAT_OFS);
  localparam logic [6:0] OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [6:0]              digit_q [NUM_DIGITS];
  logic [6:0]              digit_d [NUM_DIGITS];
  logic [2:0]              ctrl_q, ctrl_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [NUM_DIGITS*7-1:0] seg_q, seg_d;
  logic [6:0]              lit [NUM_DIGITS];
  logic [31:0]             rdata;
  logic [3:0]              scan_idx;
  logic                    blink_ph;
  logic                    we;

  assign we = bus.chipselect && !bus.write_n;

  hex_disp_prescaler #(
    .DIV (BLINK_DIV)
  ) u_blink (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (ctrl_q[CTRL_BLINK]),
    .clr   (!ctrl_q[CTRL_BLINK]),
    .phase (blink_ph)
  );

  always_comb begin
    digit_d = digit_q;
    ctrl_d  = ctrl_q;
    mask_d  = mask_q;
    if (we) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (bus.address == ADDR_W'(d))
          digit_d[d] = bus.writedata[6:0];
      end
      if (bus.address == A_CTRL)
        ctrl_d = bus.writedata[2:0];
      if (bus.address == A_MASK)
        mask_d = bus.writedata[NUM_DIGITS-1:0];
    end
  end

  always_comb begin
    seg_d = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      lit[d] = ctrl_q[CTRL_DECODE]
             ? hex_to_seg(digit_q[d][3:0])
             : digit_q[d];
      if (ctrl_q[CTRL_BLANK] ||
          (ctrl_q[CTRL_BLINK] && mask_q[d] && !blink_ph))
        lit[d] = '0;
      seg_d[7*d +: 7] = lit[d] ^ OFF;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (bus.address == A_CTRL): rdata = 32'(ctrl_q);
      (bus.address == A_MASK): rdata = 32'(mask_q);
      (bus.address == A_STAT):
        rdata = {24'd0, scan_idx, 3'd0, blink_ph};
      default: begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (bus.address == ADDR_W'(d))
            rdata = 32'(digit_q[d]);
        end
      end
    endcase
  end

  assign bus.readdata = rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        digit_q[i] <= '0;
      ctrl_q <= '0;
      mask_q <= '0;
      seg_q  <= {NUM_DIGITS{OFF}};
    end else begin
      digit_q <= digit_d;
      ctrl_q  <= ctrl_d;
      mask_q  <= mask_d;
      seg_q   <= seg_d;
    end
  end

  assign seg_out = seg_q;

`ifdef HEX_DISP_SCAN_EN
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (ACTIVE_LOW != 0) ? '1 : '0;

  logic                  scan_ph, scan_ph_q;
  logic [3:0]            idx_q, idx_d;
  logic [6:0]            sseg_q, sseg_d;
  logic [NUM_DIGITS-1:0] ssel_q, ssel_d;

  // every toggle of the free-running phase is one 2**10 tick
  hex_disp_prescaler #(
    .DIV (SCAN_DIV)
  ) u_scan (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (1'b1),
    .clr   (1'b0),
    .phase (scan_ph)
  );

  always_comb begin
    idx_d  = idx_q;
    sseg_d = OFF;
    ssel_d = SEL_OFF;
    if (scan_ph != scan_ph_q)
      idx_d = (idx_q == 4'(NUM_DIGITS - 1)) ? '0 : idx_q + 4'd1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == 4'(d)) begin
        sseg_d    = lit[d] ^ OFF;
        ssel_d[d] = ~SEL_OFF[d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_ph_q <= 1'b1;
      idx_q     <= '0;
      sseg_q    <= OFF;
      ssel_q    <= SEL_OFF;
    end else begin
      scan_ph_q <= scan_ph;
      idx_q     <= idx_d;
      sseg_q    <= sseg_d;
      ssel_q    <= ssel_d;
    end
  end

  assign scan_idx = idx_q;
  assign scan_seg = sseg_q;
  assign scan_sel = ssel_q;
`else
  assign scan_idx = 4'd0;
`endif

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// tb_hex_disp_ctrl: scoreboard bench with a cycle-level register
// model for hex_disp_ctrl (default build, BLINK_DIV=4).
module tb_hex_disp_ctrl;

  localparam int ND  = 8;
  localparam int AW  = 5;
  localparam int DIV = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [ND*7-1:0] seg_out;

  hex_disp_ctrl_if #(.ADDR_W(AW)) bus ();

  hex_disp_ctrl #(
    .NUM_DIGITS (ND),
    .ADDR_W     (AW),
    .BLINK_DIV  (DIV),
    .ACTIVE_LOW (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .seg_out (seg_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // reference: glyphs a..g for 0-F, 1 = lit
  int glyph [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                     'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  bit [6:0]  m_dig [ND];
  bit [2:0]  m_ctrl;
  bit [7:0]  m_mask;
  int        m_k;
  bit        old_en;
  int        wa;
  bit [55:0] exp_q [$];

  // phase is 1 for the first DIV cycles of blinking, then alternates
  function automatic bit m_phase();
    return !m_ctrl[1] || ((m_k / DIV) % 2 == 0);
  endfunction

  function automatic bit [55:0] m_seg();
    bit [55:0] s;
    bit [6:0]  pat;
    int        g;
    s = '0;
    for (int d = 0; d < ND; d++) begin
      g   = glyph[m_dig[d][3:0]];
      pat = m_ctrl[0] ? g[6:0] : m_dig[d];
      if (m_ctrl[2] || (m_ctrl[1] && m_mask[d] && !m_phase()))
        pat = '0;
      s[7*d +: 7] = ~pat;
    end
    return s;
  endfunction

  function automatic bit [31:0] m_rd(input int a);
    if (a < ND)      return 32'(m_dig[a]);
    if (a == ND)     return 32'(m_ctrl);
    if (a == ND + 1) return 32'(m_mask);
    if (a == ND + 2) return 32'(m_phase());
    return 32'd0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < ND; d++) m_dig[d] = '0;
      m_ctrl = '0;
      m_mask = '0;
      m_k    = 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(m_seg());
      old_en = m_ctrl[1];
      if (bus.chipselect && !bus.write_n) begin
        wa = int'(bus.address);
        if (wa < ND)           m_dig[wa] = bus.writedata[6:0];
        else if (wa == ND)     m_ctrl = bus.writedata[2:0];
        else if (wa == ND + 1) m_mask = bus.writedata[ND-1:0];
      end
      if (old_en) m_k++;
      else        m_k = 0;
      if (!m_ctrl[1]) m_k = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_n && exp_q.size() > 0)
      chk("seg_out", {8'd0, seg_out}, {8'd0, exp_q.pop_front()});
  end

  task automatic wr(input int a, input logic [31:0] v);
    @(negedge clk);
    bus.address    = AW'(a);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = v;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'($urandom_range(0, 1));
    bus.writedata  = $urandom;
  endtask

  task automatic rd_chk(input string nm, input int a);
    bus.address = AW'(a);
    #1;
    chk(nm, 64'(bus.readdata), 64'(m_rd(a)));
  endtask

  task automatic rd_const(input string nm, input int a,
                          input logic [31:0] v);
    bus.address = AW'(a);
    #1;
    chk(nm, 64'(bus.readdata), 64'(v));
  endtask

  task automatic seg_next(input string nm, input int lo,
                          input logic [6:0] v);
    @(posedge clk);
    #2;
    chk(nm, 64'(seg_out[lo +: 7]), 64'(v));
  endtask

  initial begin
    int n;
    int r;
    int a;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", 64'(seg_out), 64'({ND*7{1'b1}}));
    for (int i = 0; i <= ND + 2; i++)
      rd_const("rst_rd", i, (i == ND + 2) ? 32'd1 : 32'd0);
    rd_const("rst_rd31", 31, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    wr(ND, 32'h1);
    wr(0, 32'h3);
    seg_next("dec_d0", 0, 7'h30);
    wr(7, 32'hFFFF_FF0A);
    seg_next("dec_d7", 49, 7'h08);
    @(negedge clk);
    rd_const("rd_d0", 0, 32'h3);
    rd_const("rd_d7", 7, 32'h0A);

    wr(ND, 32'h0);
    wr(2, 32'h7F);
    seg_next("raw_d2", 14, 7'h00);
    wr(ND, 32'h4);
    seg_next("blank_d2", 14, 7'h7F);

    wr(ND + 1, 32'h01);
    wr(0, 32'h8);
    wr(ND, 32'h3);
    repeat (5) @(posedge clk);
    #2;
    chk("blink_off", 64'(seg_out[6:0]), 64'(7'h7F));
    chk("blink_d7", 64'(seg_out[55:49]), 64'(7'h08));
    repeat (4) @(posedge clk);
    #2;
    chk("blink_on", 64'(seg_out[6:0]), 64'(7'h00));
    repeat (9) @(negedge clk);
    wr(ND, 32'h1);
    rd_const("unblink_stat", ND + 2, 32'h1);
    seg_next("unblink_d0", 0, 7'h00);

    wr(ND + 2, 32'hFF);
    wr(31, 32'hFF);
    rd_const("rd31", 31, 32'h0);
    rd_const("stat_ro", ND + 2, 32'h1);
    for (int i = 0; i <= ND + 1; i++) rd_chk("edge_rd", i);

    wr(ND, 32'h3);
    n = 0;
    while (m_phase() && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      fails++;
      $display("FAIL wait_ph0 timeout cycles=%0d", n);
    end
    rd_const("ph0_stat", ND + 2, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_seg", 64'(seg_out), 64'({ND*7{1'b1}}));
    rd_const("mid_rst_stat", ND + 2, 32'h1);
    rd_const("mid_rst_ctrl", ND, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wr(ND + 1, 32'h01);
    wr(0, 32'h8);
    repeat (10) @(negedge clk);
    rd_const("no_blink_stat", ND + 2, 32'h1);
    wr(ND, 32'h3);
    repeat (12) @(negedge clk);

    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        a = ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 12);
        if (a == ND) wr(a, $urandom & 32'hFFFF_FFFB);
        else         wr(a, $urandom);
      end else if (r < 8) begin
        @(negedge clk);
        rd_chk("rand_rd", $urandom_range(0, 31));
      end else begin
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
